// File: rtl/s2mm_cmd_gen.sv
// s2mm_cmd_gen: turns a 64-bit write tag into one DataMover S2MM command and then
// forwards exactly BTT bytes of the untermed core result stream, adding a
// generated tlast and a masked final tkeep. S2MM status beats retire
// outstanding commands and latch the first error seen.
// Ports:
//   s_axis_tag_*     write tag in: [31:0] addr, [54:32] BTT, [58:55] cmd id
//   s_axis_data_*    core result stream in (no tlast / tkeep)
//   m_axis_s2mm_cmd_* 72-bit DataMover command out
//   m_axis_s2mm_*    S2MM data out, with tkeep and tlast
//   s_axis_s2mm_sts_* status in (always accepted)
//   outstanding      commands issued and still awaiting status
//   idle             nothing in flight
//   err, err_tag     sticky error flag and the cmd id of the first error
`ifndef DFLT_CORE_AXI_DATA_WIDTH
`define DFLT_CORE_AXI_DATA_WIDTH 128
`endif
`ifndef DFLT_MEM_TAG_WIDTH
`define DFLT_MEM_TAG_WIDTH 64
`endif

module s2mm_cmd_gen #(
    parameter int AXI_DATA_WIDTH  = `DFLT_CORE_AXI_DATA_WIDTH,
    parameter int S2MM_TAG_WIDTH  = `DFLT_MEM_TAG_WIDTH,
    parameter int MAX_OUTSTANDING = 16,
    localparam int BPB = AXI_DATA_WIDTH / 8,
    localparam int LB  = $clog2(BPB),
    localparam int BW  = 23 - LB + 1,
    localparam int OW  = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_axis_tag_tvalid,
    output logic                      s_axis_tag_tready,
    input  logic [S2MM_TAG_WIDTH-1:0] s_axis_tag_tdata,
    input  logic                      s_axis_data_tvalid,
    output logic                      s_axis_data_tready,
    input  logic [AXI_DATA_WIDTH-1:0] s_axis_data_tdata,
    output logic                      m_axis_s2mm_cmd_tvalid,
    input  logic                      m_axis_s2mm_cmd_tready,
    output logic [71:0]               m_axis_s2mm_cmd_tdata,
    output logic                      m_axis_s2mm_tvalid,
    input  logic                      m_axis_s2mm_tready,
    output logic [AXI_DATA_WIDTH-1:0] m_axis_s2mm_tdata,
    output logic [BPB-1:0]            m_axis_s2mm_tkeep,
    output logic                      m_axis_s2mm_tlast,
    input  logic                      s_axis_s2mm_sts_tvalid,
    output logic                      s_axis_s2mm_sts_tready,
    input  logic [7:0]                s_axis_s2mm_sts_tdata,
    output logic [OW-1:0]             outstanding,
    output logic                      idle,
    output logic                      err,
    output logic [3:0]                err_tag
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CMD  = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [22:0]   btt_q, btt_d;
    logic [3:0]    id_q, id_d;
    logic [BW-1:0] beats_q, beats_d;
    logic [OW-1:0] outst_q, outst_d;
    logic          err_q, err_d;
    logic [3:0]    err_tag_q, err_tag_d;

    logic          tag_hs, cmd_hs, data_hs, last_beat;
    logic          sts_bad;
    logic [23:0]   btt_round;
    logic [LB-1:0] rem;
    logic [BPB-1:0] last_keep;

    logic unused_tag;
    assign unused_tag = ^s_axis_tag_tdata[S2MM_TAG_WIDTH-1:59];

    assign s_axis_tag_tready  = (state_q == IDLE) &&
                                (outst_q < OW'(MAX_OUTSTANDING));
    assign tag_hs             = s_axis_tag_tvalid && s_axis_tag_tready;

    assign m_axis_s2mm_cmd_tvalid = (state_q == CMD);
    assign m_axis_s2mm_cmd_tdata  = {4'b0, id_q, addr_q, 1'b0, 1'b1,
                                     6'b0, 1'b1, btt_q};
    assign cmd_hs = m_axis_s2mm_cmd_tvalid && m_axis_s2mm_cmd_tready;

    // DATA is a pure passthrough; everywhere else both sides are held off.
    assign m_axis_s2mm_tvalid = (state_q == DATA) && s_axis_data_tvalid;
    assign s_axis_data_tready = (state_q == DATA) && m_axis_s2mm_tready;
    assign m_axis_s2mm_tdata  = s_axis_data_tdata;
    assign data_hs   = m_axis_s2mm_tvalid && m_axis_s2mm_tready;
    assign last_beat = (beats_q == BW'(1));
    assign m_axis_s2mm_tlast  = (state_q == DATA) && last_beat;

    // Final beat keeps the low (BTT mod BPB) bytes; remainder 0 means full.
    assign rem = btt_q[LB-1:0];
    always_comb begin
        last_keep = '0;
        for (int i = 0; i < BPB; i++)
            last_keep[i] = (rem == '0) || (i < int'(rem));
    end
    assign m_axis_s2mm_tkeep = last_beat ? last_keep : '1;

    assign btt_round = {1'b0, btt_q} + 24'(BPB - 1);

    assign s_axis_s2mm_sts_tready = 1'b1;
    // A status with nothing outstanding is counted as an error too.
    assign sts_bad = s_axis_s2mm_sts_tvalid &&
                     (!s_axis_s2mm_sts_tdata[7] ||
                      (|s_axis_s2mm_sts_tdata[6:4]) ||
                      (outst_q == '0));

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        btt_d     = btt_q;
        id_d      = id_q;
        beats_d   = beats_q;
        outst_d   = outst_q;
        err_d     = err_q;
        err_tag_d = err_tag_q;
        case (state_q)
            IDLE: if (tag_hs) begin
                addr_d = s_axis_tag_tdata[31:0];
                btt_d  = s_axis_tag_tdata[54:32];
                id_d   = s_axis_tag_tdata[58:55];
                if (s_axis_tag_tdata[54:32] != '0)
                    state_d = CMD;
            end
            CMD: if (cmd_hs) begin
                beats_d = BW'(btt_round >> LB);
                state_d = DATA;
            end
            DATA: if (data_hs) begin
                beats_d = beats_q - BW'(1);
                if (last_beat)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (cmd_hs && !(s_axis_s2mm_sts_tvalid && outst_q != '0))
            outst_d = outst_q + OW'(1);
        else if (!cmd_hs && s_axis_s2mm_sts_tvalid && outst_q != '0)
            outst_d = outst_q - OW'(1);
        if (sts_bad && !err_q) begin
            err_d     = 1'b1;
            err_tag_d = s_axis_s2mm_sts_tdata[3:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            btt_q     <= '0;
            id_q      <= '0;
            beats_q   <= '0;
            outst_q   <= '0;
            err_q     <= 1'b0;
            err_tag_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            btt_q     <= btt_d;
            id_q      <= id_d;
            beats_q   <= beats_d;
            outst_q   <= outst_d;
            err_q     <= err_d;
            err_tag_q <= err_tag_d;
        end
    end

    assign outstanding = outst_q;
    assign idle        = (state_q == IDLE) && (outst_q == '0);
    assign err         = err_q;
    assign err_tag     = err_tag_q;

endmodule

// File: tb/tb_s2mm_cmd_gen.sv
// tb_s2mm_cmd_gen: directed bench for s2mm_cmd_gen.
// Inputs driven 1 time unit after posedge, outputs checked 2 units after.
module tb_s2mm_cmd_gen;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         tag_v, tag_r;
    logic [63:0]  tag_d;
    logic         dat_v, dat_r;
    logic [127:0] dat_d;
    logic         cmd_v, cmd_r;
    logic [71:0]  cmd_d;
    logic         m_v, m_r;
    logic [127:0] m_d;
    logic [15:0]  m_k;
    logic         m_l;
    logic         sts_v, sts_r;
    logic [7:0]   sts_d;
    logic [4:0]   outst;
    logic         idle, err;
    logic [3:0]   err_tag;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    s2mm_cmd_gen dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .s_axis_tag_tvalid      (tag_v),
        .s_axis_tag_tready      (tag_r),
        .s_axis_tag_tdata       (tag_d),
        .s_axis_data_tvalid     (dat_v),
        .s_axis_data_tready     (dat_r),
        .s_axis_data_tdata      (dat_d),
        .m_axis_s2mm_cmd_tvalid (cmd_v),
        .m_axis_s2mm_cmd_tready (cmd_r),
        .m_axis_s2mm_cmd_tdata  (cmd_d),
        .m_axis_s2mm_tvalid     (m_v),
        .m_axis_s2mm_tready     (m_r),
        .m_axis_s2mm_tdata      (m_d),
        .m_axis_s2mm_tkeep      (m_k),
        .m_axis_s2mm_tlast      (m_l),
        .s_axis_s2mm_sts_tvalid (sts_v),
        .s_axis_s2mm_sts_tready (sts_r),
        .s_axis_s2mm_sts_tdata  (sts_d),
        .outstanding            (outst),
        .idle                   (idle),
        .err                    (err),
        .err_tag                (err_tag)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_tag(input logic [31:0] a, input logic [22:0] b,
                            input logic [3:0] id);
        int cnt = 0;
        tag_v = 1'b1;
        tag_d = {5'b0, id, b, a};
        while (!tag_r && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("tag_timeout", 128'(cnt < 100), 128'(1));
        @(posedge clk); #1;
        tag_v = 1'b0;
    endtask

    task automatic do_cmd();
        cmd_r = 1'b1;
        #1;
        chk("cmd_valid", 128'(cmd_v), 128'(1));
        @(posedge clk); #1;
        cmd_r = 1'b0;
    endtask

    task automatic beat(input logic [127:0] d, input logic [15:0] k,
                        input logic l);
        dat_v = 1'b1;
        dat_d = d;
        m_r   = 1'b1;
        #1;
        chk("beat_valid", 128'(m_v), 128'(1));
        chk("beat_data", m_d, d);
        chk("beat_keep", 128'(m_k), 128'(k));
        chk("beat_last", 128'(m_l), 128'(l));
        @(posedge clk); #1;
        dat_v = 1'b0;
    endtask

    task automatic status(input logic [7:0] s);
        sts_v = 1'b1;
        sts_d = s;
        @(posedge clk); #1;
        sts_v = 1'b0;
    endtask

    initial begin
        int idx;
        int cyc;
        logic hs;
        rst_n = 1'b0;
        tag_v = 0; tag_d = '0;
        dat_v = 0; dat_d = '0;
        cmd_r = 0; m_r = 0;
        sts_v = 0; sts_d = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_v", 128'(cmd_v), 128'(0));
        chk("rst_m_v", 128'(m_v), 128'(0));
        chk("rst_outst", 128'(outst), 128'(0));
        chk("rst_idle", 128'(idle), 128'(1));
        chk("rst_err", 128'(err), 128'(0));
        chk("rst_err_tag", 128'(err_tag), 128'(0));
        chk("rst_sts_r", 128'(sts_r), 128'(1));
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_tag_r", 128'(tag_r), 128'(1));

        // BTT=64, addr 0x1000, id 3
        send_tag(32'h1000, 23'd64, 4'd3);
        chk("t1_cmd_v", 128'(cmd_v), 128'(1));
        chk("t1_btt", 128'(cmd_d[22:0]), 128'(64));
        chk("t1_addr", 128'(cmd_d[63:32]), 128'(32'h1000));
        chk("t1_id", 128'(cmd_d[67:64]), 128'(3));
        chk("t1_eof", 128'(cmd_d[30]), 128'(1));
        chk("t1_incr", 128'(cmd_d[23]), 128'(1));
        chk("t1_full", 128'(cmd_d), 128'(72'h03_0000_1000_4080_0040));
        chk("t1_tag_r", 128'(tag_r), 128'(0));
        do_cmd();
        chk("t1_outst", 128'(outst), 128'(1));
        beat(128'hA0, 16'hFFFF, 1'b0);
        beat(128'hA1, 16'hFFFF, 1'b0);
        beat(128'hA2, 16'hFFFF, 1'b0);
        beat(128'hA3, 16'hFFFF, 1'b1);
        chk("t1_tag_r_after", 128'(tag_r), 128'(1));
        status(8'h83);
        chk("t1_outst_0", 128'(outst), 128'(0));

        // BTT=40: 3 beats, final keep 0x00FF
        cmd_r = 1'b1;
        send_tag(32'h2000, 23'd40, 4'd3);
        chk("t2_btt", 128'(cmd_d[22:0]), 128'(40));
        @(posedge clk); #1;
        cmd_r = 1'b0;
        beat(128'hB0, 16'hFFFF, 1'b0);
        beat(128'hB1, 16'hFFFF, 1'b0);
        chk("t2_outst", 128'(outst), 128'(1));
        beat(128'hB2, 16'h00FF, 1'b1);
        chk("t2_idle_busy", 128'(idle), 128'(0));
        status(8'h83);
        chk("t2_outst_0", 128'(outst), 128'(0));
        chk("t2_idle", 128'(idle), 128'(1));
        chk("t2_err", 128'(err), 128'(0));

        // BTT=1000 with back-pressure: 63 beats, final keep 0x00FF
        send_tag(32'h3000, 23'd1000, 4'd2);
        dat_v = 1'b1; m_r = 1'b1;
        #1;
        chk("t3_stall_rdy", 128'(dat_r), 128'(0));
        chk("t3_stall_v", 128'(m_v), 128'(0));
        @(posedge clk); #1;
        chk("t3_cmd_held", 128'(cmd_v), 128'(1));
        do_cmd();
        idx = 0;
        cyc = 0;
        while (idx < 63 && cyc < 2000) begin
            dat_v = 1'($urandom_range(0, 1));
            dat_d = 128'(idx);
            m_r   = 1'($urandom_range(0, 1));
            #1;
            hs = m_v && m_r;
            if (hs) begin
                chk("t3_data", m_d, 128'(idx));
                chk("t3_last", 128'(m_l), 128'(idx == 62));
                chk("t3_keep", 128'(m_k),
                    (idx == 62) ? 128'h00FF : 128'hFFFF);
            end
            @(posedge clk); #1;
            if (hs) idx++;
            cyc++;
        end
        chk("t3_beats", 128'(idx), 128'(63));
        dat_v = 1'b1; m_r = 1'b1;
        #1;
        chk("t3_no_extra", 128'(m_v), 128'(0));
        dat_v = 1'b0; m_r = 1'b0;
        @(posedge clk); #1;
        status(8'h82);

        // 16 outstanding commands, single-beat each
        for (int i = 0; i < 16; i++) begin
            send_tag(32'h4000 + 32'(i * 16), 23'd16, 4'(i));
            do_cmd();
            beat(128'(i), 16'hFFFF, 1'b1);
        end
        chk("t4_outst16", 128'(outst), 128'(16));
        chk("t4_tag_r", 128'(tag_r), 128'(0));
        status(8'h80);
        chk("t4_outst15", 128'(outst), 128'(15));
        chk("t4_tag_r1", 128'(tag_r), 128'(1));
        send_tag(32'h5000, 23'd16, 4'd9);
        cmd_r = 1'b1; sts_v = 1'b1; sts_d = 8'h81;
        #1;
        chk("t4_cmd_v", 128'(cmd_v), 128'(1));
        @(posedge clk); #1;
        cmd_r = 1'b0; sts_v = 1'b0;
        chk("t4_outst_hold", 128'(outst), 128'(15));
        beat(128'h55, 16'hFFFF, 1'b1);
        sts_v = 1'b1; sts_d = 8'h80;
        repeat (15) @(posedge clk);
        #1;
        sts_v = 1'b0;
        chk("t4_drain", 128'(outst), 128'(0));
        chk("t4_idle", 128'(idle), 128'(1));
        chk("t4_err", 128'(err), 128'(0));

        // errors: first error tag kept, BTT=0 dropped
        send_tag(32'h6000, 23'd16, 4'd5);
        do_cmd();
        beat(128'h66, 16'hFFFF, 1'b1);
        status(8'h45);
        chk("t5_err", 128'(err), 128'(1));
        chk("t5_err_tag", 128'(err_tag), 128'(5));
        chk("t5_outst", 128'(outst), 128'(0));
        status(8'h26);
        chk("t5_err_tag_kept", 128'(err_tag), 128'(5));
        chk("t5_outst_sat", 128'(outst), 128'(0));
        send_tag(32'h7000, 23'd0, 4'd1);
        chk("t5_btt0_cmd", 128'(cmd_v), 128'(0));
        chk("t5_btt0_rdy", 128'(tag_r), 128'(1));
        chk("t5_btt0_idle", 128'(idle), 128'(1));
        @(posedge clk); #1;
        chk("t5_btt0_cmd2", 128'(cmd_v), 128'(0));

        // reset in the middle of a burst
        send_tag(32'h8000, 23'd64, 4'd7);
        do_cmd();
        beat(128'h80, 16'hFFFF, 1'b0);
        dat_v = 1'b1; m_r = 1'b1;
        #1;
        chk("t6_pre_v", 128'(m_v), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("t6_rst_v", 128'(m_v), 128'(0));
        chk("t6_rst_last", 128'(m_l), 128'(0));
        chk("t6_rst_cmd", 128'(cmd_v), 128'(0));
        chk("t6_rst_outst", 128'(outst), 128'(0));
        chk("t6_rst_err", 128'(err), 128'(0));
        dat_v = 1'b0; m_r = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_tag(32'h9000, 23'd16, 4'd4);
        chk("t6_cmd", 128'(cmd_d), 128'(72'h04_0000_9000_4080_0010));
        do_cmd();
        chk("t6_outst", 128'(outst), 128'(1));
        beat(128'h99, 16'hFFFF, 1'b1);
        status(8'h84);
        chk("t6_idle", 128'(idle), 128'(1));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
